// File: rtl/seg_display_scheduler.sv
// Round-robin owner of a 4-digit seven-segment display with per-source dwell.
// Scans digits from its own prescaler and snapshots the owner's data per frame.
module seg_display_scheduler #(
    parameter int unsigned DIVIDE_BY    = 17,
    parameter int unsigned DWELL_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic        lock,
    output logic [2:0]  grant,
    output logic [3:0]  anode,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(DWELL_FRAMES + 1);
    localparam logic [CW-1:0] DWELL = CW'(DWELL_FRAMES);

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           last_q, last_d;
    logic [DIVIDE_BY-1:0] presc_q, presc_d;
    logic [1:0]           idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [15:0]          snap_q, snap_d;
    logic [2:0]           grant_q, grant_d;
    logic [3:0]           anode_q, anode_d;
    logic [3:0]           digit_q, digit_d;
    logic                 fd_q, fd_d;

    logic                 tick;
    logic                 frame_end;
    logic [2:0]           cur_oh;
    logic                 cur_req;
    logic                 others_req;
    logic [CW-1:0]        cnt_inc;
    logic                 rr_hit;
    logic [1:0]           rr_win;
    logic [1:0]           cand;
    logic                 take;

    function automatic logic [15:0] src_data(
        input logic [1:0]  s,
        input logic [15:0] d0,
        input logic [15:0] d1,
        input logic [15:0] d2
    );
        case (s)
            2'd0:    return d0;
            2'd1:    return d1;
            default: return d2;
        endcase
    endfunction

    assign tick       = &presc_q;
    assign frame_end  = (state_q == SHOW) && tick && (idx_q == 2'd3);
    assign cur_oh     = 3'b001 << last_q;
    assign cur_req    = |(req & cur_oh);
    assign others_req = |(req & ~cur_oh);
    assign cnt_inc    = (cnt_q == DWELL) ? cnt_q : cnt_q + 1'b1;

    // Search last+1, last+2, last+3 (mod 3); the owner itself is tried last.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = last_q;
        cand   = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_q) + k) % 3);
            if (!rr_hit && req[cand]) begin
                rr_hit = 1'b1;
                rr_win = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'd2;
            presc_q <= '0;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            snap_q  <= 16'h0000;
            grant_q <= 3'b000;
            anode_q <= 4'b1111;
            digit_q <= 4'h0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            grant_q <= grant_d;
            anode_q <= anode_d;
            digit_q <= digit_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        fd_d    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                idx_d   = 2'd0;
                cnt_d   = '0;
                take    = rr_hit;
            end
            SHOW: begin
                presc_d = presc_q + 1'b1;
                if (tick) begin
                    idx_d = idx_q + 2'd1;
                end
                if (frame_end) begin
                    fd_d   = 1'b1;
                    cnt_d  = cnt_inc;
                    snap_d = src_data(last_q, data0, data1, data2);
                    if (!cur_req) begin
                        if (rr_hit) begin
                            take = 1'b1;
                        end else begin
                            state_d = IDLE;
                            presc_d = '0;
                            idx_d   = 2'd0;
                            cnt_d   = '0;
                        end
                    end else if (cnt_inc == DWELL && !lock && others_req) begin
                        take = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A hand-off looks exactly like a fresh grant out of IDLE.
        if (take) begin
            state_d = SHOW;
            last_d  = rr_win;
            presc_d = '0;
            idx_d   = 2'd0;
            cnt_d   = '0;
            snap_d  = src_data(rr_win, data0, data1, data2);
        end
    end

    // Outputs are computed from next state so they register in step with it.
    always_comb begin
        grant_d = 3'b000;
        anode_d = 4'b1111;
        digit_d = 4'h0;
        if (state_d == SHOW) begin
            grant_d = 3'b001 << last_d;
            anode_d = ~(4'b0001 << idx_d);
            case (idx_d)
                2'd0:    digit_d = snap_d[3:0];
                2'd1:    digit_d = snap_d[7:4];
                2'd2:    digit_d = snap_d[11:8];
                default: digit_d = snap_d[15:12];
            endcase
        end
    end

    assign grant      = grant_q;
    assign anode      = anode_q;
    assign digit      = digit_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler, DIVIDE_BY=2, DWELL_FRAMES=2.
// Stimulus is a linear sequence; every check is an immediate assertion.
module tb_seg_display_scheduler;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        lock;
    logic [2:0]  grant;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_display_scheduler #(
        .DIVIDE_BY   (2),
        .DWELL_FRAMES(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .lock      (lock),
        .grant     (grant),
        .anode     (anode),
        .digit     (digit),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] g,
                           input logic [3:0] a, input logic [3:0] d,
                           input logic f);
        chk(tag, {4'h0, grant, anode, digit, frame_done},
            {4'h0, g, a, d, f});
    endtask

    logic [2:0]  gseq [4];
    logic [3:0]  exp_an;
    logic [3:0]  exp_dg;
    logic [15:0] nib;

    initial begin
        reset = 1'b0;
        req   = 3'b111;
        data0 = 16'h4321;
        data1 = 16'hDCBA;
        data2 = 16'h5F6E;
        lock  = 1'b0;

        // Reset holds everything quiet even with all requests high
        for (int i = 0; i < 5; i++) begin
            step();
            chk_all("reset_hold", 3'b000, 4'b1111, 4'h0, 1'b0);
        end

        // Single source scan
        req = 3'b000;
        step();
        reset = 1'b1;
        step();
        chk_all("idle_no_req", 3'b000, 4'b1111, 4'h0, 1'b0);
        req = 3'b001;
        step();
        nib = 16'h4321;
        for (int i = 0; i < 32; i++) begin
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            exp_dg = 4'((i / 4) % 4 + 1);
            chk_all("single_scan", 3'b001, exp_an, exp_dg,
                    (i > 0) && (i % 16 == 0));
            step();
        end

        // Snapshot: data change mid-frame is invisible until the next frame
        chk_all("snap_frame_start", 3'b001, 4'b1110, 4'h1, 1'b1);
        repeat (4) step();
        chk_all("snap_digit2", 3'b001, 4'b1101, 4'h2, 1'b0);
        data0 = 16'h8765;
        repeat (4) step();
        chk_all("snap_old_d3", 3'b001, 4'b1011, 4'h3, 1'b0);
        repeat (4) step();
        chk_all("snap_old_d4", 3'b001, 4'b0111, 4'h4, 1'b0);
        repeat (4) step();
        chk_all("snap_new_d5", 3'b001, 4'b1110, 4'h5, 1'b1);
        repeat (4) step();
        chk_all("snap_new_d6", 3'b001, 4'b1101, 4'h6, 1'b0);

        // Release mid-frame: frame completes, then idle
        req = 3'b000;
        repeat (4) step();
        chk_all("rel_d7", 3'b001, 4'b1011, 4'h7, 1'b0);
        repeat (4) step();
        chk_all("rel_d8", 3'b001, 4'b0111, 4'h8, 1'b0);
        repeat (3) step();
        chk("rel_last_cycle", {13'h0, grant}, 16'h0001);
        step();
        chk("rel_grant", {13'h0, grant}, 16'h0000);
        chk("rel_anode", {12'h0, anode}, 16'h000F);
        chk("rel_digit", {12'h0, digit}, 16'h0000);
        step();
        chk_all("rel_idle", 3'b000, 4'b1111, 4'h0, 1'b0);
        req = 3'b001;
        step();
        chk_all("regrant", 3'b001, 4'b1110, 4'h5, 1'b0);

        // Rotation from reset
        reset = 1'b0;
        req   = 3'b111;
        data0 = 16'h4321;
        step();
        chk_all("rot_reset", 3'b000, 4'b1111, 4'h0, 1'b0);
        reset = 1'b1;
        step();
        gseq[0] = 3'b001;
        gseq[1] = 3'b010;
        gseq[2] = 3'b100;
        gseq[3] = 3'b001;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 32; i++) begin
                chk("rot_grant", {13'h0, grant}, {13'h0, gseq[s]});
                step();
            end
        end
        chk("rot_wrap", {13'h0, grant}, {13'h0, gseq[3]});
        chk("rot_wrap_an", {12'h0, anode}, 16'h000E);
        chk("rot_wrap_dg", {12'h0, digit}, 16'h0001);

        // Lock holds source 1 past its dwell
        repeat (32) step();
        chk_all("lock_start", 3'b010, 4'b1110, 4'hA, 1'b1);
        lock = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            if (i % 10 == 9)
                chk("lock_hold", {13'h0, grant}, 16'h0002);
        end
        lock = 1'b0;
        repeat (7) step();
        chk("lock_last", {13'h0, grant}, 16'h0002);
        step();
        chk_all("unlock_rot", 3'b100, 4'b1110, 4'hE, 1'b1);

        // Mid-frame reset, then source 0 wins first again
        repeat (64) step();
        chk("mid_pre_g", {13'h0, grant}, 16'h0002);
        repeat (8) step();
        chk_all("mid_idx2", 3'b010, 4'b1011, 4'hC, 1'b0);
        reset = 1'b0;
        step();
        chk_all("mid_reset", 3'b000, 4'b1111, 4'h0, 1'b0);
        reset = 1'b1;
        step();
        chk_all("post_reset", 3'b001, 4'b1110, 4'h1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_scheduler.md
# seg_display_scheduler

Time-shares the four-digit seven-segment display among three requesting data sources: sum, difference and raw switches. Arbitration is round-robin with a per-source dwell time. The block also performs the digit scanning itself, using an internal prescaler on the single system clock. Its anode output drives the display directly, and its digit nibble feeds the seven-segment decoder.

## Interface
- `DIVIDE_BY`, default 17: prescaler width. The scan tick occurs once every 2^DIVIDE_BY clock cycles.
- `DWELL_FRAMES`, default 64: number of complete 4-digit frames a source keeps the display before rotation is considered. Must be ≥ 1.
- `clock`, in, 1: system clock (100 MHz). All state changes on the rising edge.
- `reset`, in, 1: one clock; reset is synchronous and active-low (`reset`=0 resets on the next rising edge).
- `req`, in, 3: request lines, one bit per source 0..2. Level-sensitive.
- `data0`, in, 16: four nibbles for source 0; nibble k is `data0[4k+3:4k]`.
- `data1`, in, 16: four nibbles for source 1, same layout.
- `data2`, in, 16: four nibbles for source 2, same layout.
- `lock`, in, 1: while high, suppresses rotation away from the current grantee.
- `grant`, out, 3: one-hot index of the source currently displayed; 000 when idle.
- `anode`, out, 4: active-low one-hot digit enable; 1111 = blank.
- `digit`, out, 4: nibble for the currently enabled digit; 0 when idle.
- `frame_done`, out, 1: one-cycle pulse at each completed frame while granted.

## Operation
- Prescaler: a DIVIDE_BY-bit counter. `tick` is asserted for the cycle in which the count is all ones; the count then wraps to 0. The prescaler is cleared on every grant change.
- Scan: a 2-bit index `idx` advances on each tick (3→0 wraps). `anode = ~(4'b0001 << idx)`; `digit = snap[4*idx+3:4*idx]`.
- Snapshot: a 16-bit `snap` register loads the granted source's data on a grant change and on each frame wrap. Input changes during a frame are invisible until the next frame.
- States: IDLE and SHOW.
- IDLE: `grant`=000, `anode`=1111, `digit`=0.
  - If `req` ≠ 0, grant the first requester after round-robin pointer `last`, searching in order last+1, last+2, last+3 (mod 3).
  - On that edge: go to SHOW, set `last`=winner, `idx`=0, load `snap`, clear the frame count.
- SHOW, per frame end (tick with `idx`=3):
  - Pulse `frame_done`.
  - Increment the frame count, saturating at DWELL_FRAMES.
  - If the grantee's `req` is low: hand off to the next requester in round-robin order, or go to IDLE if none.
  - Else if count = DWELL_FRAMES, `lock`=0, and another source requests: hand off to the next requester in round-robin order.
  - Else: stay. If count = DWELL_FRAMES and no hand-off occurred, the count stays saturated, so rotation is re-evaluated at every later frame end.
- A hand-off behaves like an IDLE grant: `grant`, `snap`, `idx`=0 and the count update on the same edge, with no blank cycle.
- A requester dropping mid-frame never truncates the frame. Release happens only at frame end.
- `lock` only blocks rotation. It does not hold a grantee whose `req` dropped.
- Reset values: `grant`=000, `anode`=1111, `digit`=0, `frame_done`=0, state IDLE, `last`=2 (so source 0 wins first), prescaler 0, `idx` 0, count 0, `snap` 0.

## Timing
- All outputs are registered.
- Grant latency from IDLE: `req` sampled high at edge N gives `grant`, `anode`=1110 and `digit`=nibble 0 valid after edge N.
- Each digit is shown for exactly 2^DIVIDE_BY cycles, and one frame lasts 4·2^DIVIDE_BY cycles.
- `frame_done` is high for the one cycle following the frame-end edge. The hand-off or release occurs on that same edge.
- Minimum ownership is DWELL_FRAMES frames, unless the grantee releases.
- Reset takes priority over every other event, including a mid-frame reset: on the next edge all outputs take their reset values.
- `req` changes in the same cycle as a frame end are honoured, since they are sampled at that edge.

## Test plan
All scenarios use DIVIDE_BY=2 (tick every 4 cycles) and DWELL_FRAMES=2.
1. Reset: `reset`=0 with `req`=111 for 5 cycles → `grant`=000, `anode`=1111, `digit`=0, `frame_done`=0 throughout.
2. Single source: `req`=001, `data0`=16'h4321 → `grant`=001 one cycle later. `anode` cycles 1110/1101/1011/0111 for 4 cycles each, with `digit` 1/2/3/4. `frame_done` pulses every 16 cycles. The grant holds indefinitely.
3. Rotation: `req`=111 from reset → `grant` sequence 001, 010, 100, 001, each held 32 cycles, with no blank cycle between.
4. Lock: assert `lock` while `grant`=010 and `req`=111 → `grant` stays 010 for more than 100 cycles. Deassert `lock` → `grant`=100 at the next frame end.
5. Release and snapshot:
   - Change `data0` from 16'h4321 to 16'h8765 while `digit`=2 → the frame still shows 3, 4, then the next frame shows 5, 6, 7, 8.
   - Drop `req`=000 during `idx`=1 → the frame completes, then `grant`=000 and `anode`=1111.
   - Raise `req`=001 again → granted one cycle later.
6. Reset mid-frame: `reset`=0 while `grant`=010 and `idx`=2 → next edge `grant`=000, `anode`=1111. After release with `req`=111 → source 0 is granted first.
